y_pixel_filling: RTL and testbench
==================================

// Module: y_pixel_filling
// PURPOSE
//  Downstream neighbour of x_pixel_filling: fills one-pixel gaps in the Y direction of the
//  320x240 binary image held in the shared 32-bit frame RAM. A pixel is forced to FILL_VALUE
//  when the pixels directly above and below both equal FILL_VALUE; otherwise it is rewritten unchanged.
//  Runs in place on the same RAM after the X-filling pass; owns the RAM bus only while enabled.
// PARAMETERS
//  IMG_WIDTH   320    pixels per line; vertical neighbours are at ptr-IMG_WIDTH and ptr+IMG_WIDTH
//  START_ADDR  2240   first processed pixel address (skips top 7 lines); must be >= IMG_WIDTH
//  END_ADDR    74560  first unprocessed address (skips bottom 7 lines); END_ADDR-1+IMG_WIDTH < 2^18
//  FILL_VALUE  1      32-bit marker value meaning "pixel set"
// PORTS
//  clk_div_by_two          in   1   block clock, all logic on rising edge
//  reset                   in   1   asynchronous, active-high reset
//  enable_y_pixel_filling  in   1   level request from the top-level sequencer; holds the bus grant
//  data_read               in   32  RAM read data, valid 1 cycle after address is presented
//  wren                    out  1   RAM write enable
//  data_write              out  32  RAM write data
//  address                 out  18  RAM address
//  y_pixel_filling_done    out  1   pass complete; held until enable drops
// BEHAVIOUR
//  Reset (async): state=IDLE, ptr=START_ADDR, done=0, wren/address/data_write = high-Z.
//  Bus release: whenever enable=0, wren/address/data_write are high-Z and done=0 next edge.
//  FSM (one state per clock, 5 clocks per pixel):
//   IDLE   : enable=1 -> SETUP.
//   SETUP  : ptr<=START_ADDR; address<=START_ADDR; wren<=0 -> RD_C.
//   RD_C   : center word presented last cycle; address<=ptr+IMG_WIDTH -> RD_B.
//   RD_B   : capture center<=data_read; address<=ptr-IMG_WIDTH -> RD_A.
//   RD_A   : capture below<=data_read -> WR (above captured on entry to WR).
//   WR     : above<=data_read; address<=ptr; data_write<= (above==FILL && below==FILL) ? FILL : center;
//            wren<=1 -> NEXT.
//   NEXT   : wren<=0; if ptr+1==END_ADDR -> DONE else ptr<=ptr+1, address<=ptr+1 -> RD_C.
//   DONE   : done<=1, wren<=0; stays until enable=0 -> IDLE.
//  Compare is full 32-bit equality; address arithmetic 18-bit unsigned, no wrap within legal params.
//  wren is high for exactly one clock per pixel; address stable during the whole wren cycle.
//  In-place hazard accepted: "above" reads an already-updated pixel (top-down propagation intended).
//  enable dropped mid-pass: abort on next edge -> IDLE, bus high-Z, done=0; re-enable restarts at START.
//  enable re-asserted while DONE already reached: no re-run until enable has been low for >=1 clock.
//  reset mid-pass: immediate abort per reset values; partial RAM writes are not rolled back.
// CONFIGURATION
//  Y_PIXEL_FILLING_WRITE_SKIP_EN defined: in WR, if new value == center, wren stays 0 (no RAM write);
//   pixel still takes 5 clocks, so pass length is unchanged.
//  Not defined: every processed pixel is written back (wren pulses once per pixel).
// TESTING
//  1 Column at x=10: lines 9 and 11 = 1, line 10 = 0 -> addr 3210 rewritten to 1, done after 74560-2240 pixels.
//  2 Only line above = 1, below = 0 -> center unchanged (value 0 written back / no write with SKIP_EN).
//  3 Center = 0x00FF00FF, above=below=1 -> 1 written; above=1, below=2 -> 0x00FF00FF kept.
//  4 Count cycles enable->done = 1 + 5*72320 + 1; done stays 1 while enable=1, drops 1 clk after enable=0.
//  5 Drop enable at pixel 1000 -> next edge bus high-Z, done=0; re-enable -> first address 2240.
//  6 Assert reset during WR -> wren/address high-Z immediately (async), done=0, restart from SETUP.

Source files
------------

// File: rtl/y_pixel_filling.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : y_pixel_filling                                               |
// | Purpose  : in-place vertical one-pixel gap fill over the shared frame    |
// |            RAM; optional macro Y_PIXEL_FILLING_WRITE_SKIP_EN suppresses  |
// |            write-back of pixels whose value does not change.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module y_pixel_filling #(
   parameter logic [17:0] IMG_WIDTH  = 18'd320,
   parameter logic [17:0] START_ADDR = 18'd2240,
   parameter logic [17:0] END_ADDR   = 18'd74560,
   parameter logic [31:0] FILL_VALUE = 32'd1
) (
   input  logic        clk_div_by_two,
   input  logic        reset,
   input  logic        enable_y_pixel_filling,
   input  logic [31:0] data_read,
   output logic        wren,
   output logic [31:0] data_write,
   output logic [17:0] address,
   output logic        y_pixel_filling_done
);

   localparam logic [2:0] c_s_idle  = 3'd0;
   localparam logic [2:0] c_s_setup = 3'd1;
   localparam logic [2:0] c_s_rd_c  = 3'd2;
   localparam logic [2:0] c_s_rd_b  = 3'd3;
   localparam logic [2:0] c_s_rd_a  = 3'd4;
   localparam logic [2:0] c_s_wr    = 3'd5;
   localparam logic [2:0] c_s_next  = 3'd6;
   localparam logic [2:0] c_s_done  = 3'd7;

   logic [2:0]  r_state;
   logic [17:0] r_ptr;
   logic [17:0] r_address;
   logic [31:0] r_data_write;
   logic [31:0] r_center;
   logic [31:0] r_below;
   logic        r_wren;
   logic        r_done;
   logic        r_bus_en;

   logic [17:0] w_ptr_inc;
   logic [31:0] w_new_value;
   logic        w_write_en;

   assign w_ptr_inc = r_ptr + 18'd1;

   // data_read holds the "above" word while in WR
   assign w_new_value = ((data_read == FILL_VALUE) && (r_below == FILL_VALUE))
                        ? FILL_VALUE : r_center;

`ifdef Y_PIXEL_FILLING_WRITE_SKIP_EN
   assign w_write_en = (w_new_value != r_center);
`else
   assign w_write_en = 1'b1;
`endif

   always_ff @(posedge clk_div_by_two or posedge reset) begin
      if (reset) begin
         r_state      <= c_s_idle;
         r_ptr        <= START_ADDR;
         r_address    <= START_ADDR;
         r_data_write <= 32'd0;
         r_center     <= 32'd0;
         r_below      <= 32'd0;
         r_wren       <= 1'b0;
         r_done       <= 1'b0;
         r_bus_en     <= 1'b0;
      end else if (!enable_y_pixel_filling) begin
         r_state  <= c_s_idle;
         r_wren   <= 1'b0;
         r_done   <= 1'b0;
         r_bus_en <= 1'b0;
      end else begin
         r_bus_en <= 1'b1;
         case (r_state)
            c_s_idle: begin
               r_wren  <= 1'b0;
               r_state <= c_s_setup;
            end
            c_s_setup: begin
               r_ptr     <= START_ADDR;
               r_address <= START_ADDR;
               r_wren    <= 1'b0;
               r_state   <= c_s_rd_c;
            end
            c_s_rd_c: begin
               r_address <= r_ptr + IMG_WIDTH;
               r_state   <= c_s_rd_b;
            end
            c_s_rd_b: begin
               r_center  <= data_read;
               r_address <= r_ptr - IMG_WIDTH;
               r_state   <= c_s_rd_a;
            end
            c_s_rd_a: begin
               r_below <= data_read;
               r_state <= c_s_wr;
            end
            c_s_wr: begin
               r_address    <= r_ptr;
               r_data_write <= w_new_value;
               r_wren       <= w_write_en;
               r_state      <= c_s_next;
            end
            c_s_next: begin
               r_wren <= 1'b0;
               if (w_ptr_inc == END_ADDR) begin
                  r_done  <= 1'b1;
                  r_state <= c_s_done;
               end else begin
                  r_ptr     <= w_ptr_inc;
                  r_address <= w_ptr_inc;
                  r_state   <= c_s_rd_c;
               end
            end
            c_s_done: begin
               r_done <= 1'b1;
               r_wren <= 1'b0;
            end
            default: begin
               r_wren  <= 1'b0;
               r_state <= c_s_idle;
            end
         endcase
      end
   end

   // Bus is released combinationally from r_bus_en so an async reset floats it at once
   assign wren       = r_bus_en ? r_wren       : 1'bz;
   assign address    = r_bus_en ? r_address    : {18{1'bz}};
   assign data_write = r_bus_en ? r_data_write : {32{1'bz}};

   assign y_pixel_filling_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_y_pixel_filling.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_y_pixel_filling                                            |
// | Purpose  : directed self-checking bench on a reduced 8x8 image           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_y_pixel_filling;

   localparam logic [17:0] C_W     = 18'd8;
   localparam logic [17:0] C_START = 18'd16;
   localparam logic [17:0] C_END   = 18'd48;
   localparam int          C_NPIX  = 32;
   localparam logic [17:0] C_FLOAT_A = 18'h3FFFF;
   localparam logic [31:0] C_FLOAT_D = 32'hFFFFFFFF;

   logic        clk_div_by_two = 1'b0;
   logic        reset = 1'b1;
   logic        enable_y_pixel_filling = 1'b0;
   logic [31:0] r_q = 32'd0;
   tri1         wren;
   tri1  [31:0] data_write;
   tri1  [17:0] address;
   logic        y_pixel_filling_done;

   logic [31:0] mem [0:63];
   logic [31:0] img [0:63];
   logic [31:0] exp_img [0:63];
   logic        load_req = 1'b0;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int run_len = 0;
   int max_run = 0;

   y_pixel_filling #(
      .IMG_WIDTH (C_W),
      .START_ADDR(C_START),
      .END_ADDR  (C_END),
      .FILL_VALUE(32'd1)
   ) dut (
      .clk_div_by_two        (clk_div_by_two),
      .reset                 (reset),
      .enable_y_pixel_filling(enable_y_pixel_filling),
      .data_read             (r_q),
      .wren                  (wren),
      .data_write            (data_write),
      .address               (address),
      .y_pixel_filling_done  (y_pixel_filling_done)
   );

   always #5 clk_div_by_two = ~clk_div_by_two;

   // Synchronous RAM: read data valid the cycle after the address
   always @(posedge clk_div_by_two) begin
      if (load_req) begin
         for (int i = 0; i < 64; i++) mem[i] <= img[i];
      end else begin
         if (address < 18'd64) r_q <= mem[address[5:0]];
         else                  r_q <= 32'd0;
         if (wren === 1'b1 && address < 18'd64) mem[address[5:0]] <= data_write;
      end
   end

   always @(negedge clk_div_by_two) begin
      if (wren === 1'b1 && address !== C_FLOAT_A) begin
         wr_count = wr_count + 1;
         run_len  = run_len + 1;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
   end

   task automatic tick();
      @(posedge clk_div_by_two);
      #1;
   endtask

   task automatic load_image();
      for (int i = 0; i < 64; i++) img[i] = 32'd0;
      img[8]  = 32'd1; img[24] = 32'd1;
      img[9]  = 32'd1;
      img[10] = 32'd1; img[18] = 32'h00FF00FF; img[26] = 32'd1;
      img[19] = 32'd1; img[35] = 32'd1;
      img[12] = 32'd1; img[20] = 32'h00FF00FF; img[28] = 32'd2;
      img[13] = 32'd1; img[29] = 32'd1; img[45] = 32'd1;
      img[39] = 32'd1; img[55] = 32'd1;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic check_released(input string name);
      checks++;
      if (wren !== 1'b1 || address !== C_FLOAT_A || data_write !== C_FLOAT_D ||
          y_pixel_filling_done !== 1'b0) begin
         errors++;
         $display("FAIL %s: wren=%b address=%h data_write=%h done=%b, required bus floating and done=0",
                  name, wren, address, data_write, y_pixel_filling_done);
      end
   endtask

   task automatic check_first_addr(input string name);
      checks++;
      if (address !== C_START || wren !== 1'b0) begin
         errors++;
         $display("FAIL %s: address=%0d wren=%b, required address=%0d wren=0",
                  name, address, wren, C_START);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable_y_pixel_filling = 1'b0;
      #3;
      check_released("reset_idle");
      enable_y_pixel_filling = 1'b1;
      tick();
      tick();
      check_released("reset_with_enable");
      enable_y_pixel_filling = 1'b0;
      reset = 1'b0;
      tick();
      check_released("after_reset_disabled");
   endtask

   task automatic test_abort();
      int base;
      int n;
      load_image();
      base = wr_count;
      enable_y_pixel_filling = 1'b1;
      tick();
      tick();
      check_first_addr("first_address");
      n = 0;
      while ((wr_count - base) < 10 && n < 500) begin
         tick();
         n++;
      end
      checks++;
      if ((wr_count - base) < 10) begin
         errors++;
         $display("FAIL abort_reach: writes=%0d, required 10 within budget", wr_count - base);
      end
      enable_y_pixel_filling = 1'b0;
      tick();
      check_released("abort_release");
      enable_y_pixel_filling = 1'b1;
      tick();
      tick();
      check_first_addr("abort_restart");
      enable_y_pixel_filling = 1'b0;
      tick();
   endtask

   task automatic test_fill_pass();
      int base;
      int n;
      int exp_writes;
      logic held;
      load_image();
      for (int i = 0; i < 64; i++) exp_img[i] = img[i];
      exp_img[16] = 32'd1;
      exp_img[18] = 32'd1;
      exp_img[21] = 32'd1;
      exp_img[27] = 32'd1;
      exp_img[37] = 32'd1;
      exp_img[47] = 32'd1;
`ifdef Y_PIXEL_FILLING_WRITE_SKIP_EN
      exp_writes = 6;
`else
      exp_writes = C_NPIX;
`endif
      base = wr_count;
      max_run = 0;
      enable_y_pixel_filling = 1'b1;
      n = 0;
      while (y_pixel_filling_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (n != 2 + 5 * C_NPIX) begin
         errors++;
         $display("FAIL pass_cycles: cycles=%0d, required %0d", n, 2 + 5 * C_NPIX);
      end
      checks++;
      if (wr_count - base != exp_writes) begin
         errors++;
         $display("FAIL write_count: writes=%0d, required %0d", wr_count - base, exp_writes);
      end
      checks++;
      if (max_run != 1) begin
         errors++;
         $display("FAIL wren_width: longest wren run=%0d, required 1", max_run);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (mem[i] !== exp_img[i]) begin
            errors++;
            $display("FAIL ram[%0d]: got %h, required %h", i, mem[i], exp_img[i]);
         end
      end
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (y_pixel_filling_done !== 1'b1) held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin
         errors++;
         $display("FAIL done_hold: done dropped while enable=1, required held at 1");
      end
   endtask

   task automatic test_no_rerun();
      int base;
      base = wr_count;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (wr_count != base || y_pixel_filling_done !== 1'b1) begin
         errors++;
         $display("FAIL no_rerun: writes=%0d done=%b, required 0 writes and done=1",
                  wr_count - base, y_pixel_filling_done);
      end
      enable_y_pixel_filling = 1'b0;
      tick();
      check_released("done_drop");
      enable_y_pixel_filling = 1'b1;
      tick();
      tick();
      check_first_addr("rerun_start");
   endtask

   task automatic test_reset_mid_pass();
      int n;
      n = 0;
      while (!(wren === 1'b1 && address !== C_FLOAT_A) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!(wren === 1'b1 && address !== C_FLOAT_A)) begin
         errors++;
         $display("FAIL find_write: wren=%b, required a write pulse within budget", wren);
      end
      for (int i = 0; i < 4; i++) tick();
      #2;
      reset = 1'b1;
      #1;
      check_released("async_reset_in_wr");
      tick();
      reset = 1'b0;
      tick();
      tick();
      check_first_addr("reset_restart");
      enable_y_pixel_filling = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_abort();
      test_fill_pass();
      test_no_rerun();
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
